// File: rtl/decoder_scan_nx_if.sv
// Bus bundle for decoder_scan_nx: address/enable/mode/hold in, decoded lines and scan status out.
// The i_/o_ prefixes are from the point of view of the decoder (slave).
interface decoder_scan_nx_if #(
  parameter int ADDR_W = 3
) ();
  logic [ADDR_W-1:0]      i_data_in;
  logic [3:1]             i_enable;
  logic                   i_mode;
  logic                   i_hold;
  logic [2**ADDR_W-1:0]   o_eq;
  logic [ADDR_W-1:0]      o_scan_addr;
  logic                   o_wrap;

  modport master (
    output i_data_in, i_enable, i_mode, i_hold,
    input  o_eq, o_scan_addr, o_wrap
  );

  modport slave (
    input  i_data_in, i_enable, i_mode, i_hold,
    output o_eq, o_scan_addr, o_wrap
  );
endinterface

// File: rtl/decoder_scan_nx.sv
// Registered active-low one-hot line decoder with an optional auto-scan mode:
// a prescaled address counter walks 0..SCAN_LAST with post-step dead-time blanking.
module decoder_scan_nx #(
  parameter int ADDR_W    = 3,
  parameter int SCAN_DIV  = 4,
  parameter int SCAN_LAST = 2**ADDR_W-1,
  parameter int DEAD      = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  decoder_scan_nx_if.slave io_bus
);
  localparam int OUT_W = 2**ADDR_W;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DED_W = (DEAD > 0) ? $clog2(DEAD+1) : 1;

  localparam logic [PRE_W-1:0]  PRE_TOP   = PRE_W'(SCAN_DIV-1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SCAN_LAST);
  localparam logic [DED_W-1:0]  DEAD_LD   = DED_W'(DEAD);

  logic [PRE_W-1:0]  r_presc;
  logic [ADDR_W-1:0] r_scan_addr;
  logic [DED_W-1:0]  r_dead;
  logic [OUT_W-1:0]  r_eq;
  logic              r_wrap;

  logic              w_en;
  logic              w_tick;
  logic [PRE_W-1:0]  w_presc_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DED_W-1:0]  w_dead_next;
  logic              w_wrap_next;
  logic [ADDR_W-1:0] w_sel_next;
  logic [OUT_W-1:0]  w_eq_next;

  assign w_en   = io_bus.i_enable[1] & ~io_bus.i_enable[2] & ~io_bus.i_enable[3];
  assign w_tick = io_bus.i_mode & (r_presc == PRE_TOP) & ~io_bus.i_hold;

  always_comb begin
    w_presc_next = '0;
    w_addr_next  = '0;
    w_dead_next  = '0;
    w_wrap_next  = 1'b0;
    w_sel_next   = io_bus.i_data_in;
    if (io_bus.i_mode) begin
      if (w_tick) begin
        w_presc_next = '0;
        w_addr_next  = (r_scan_addr == ADDR_LAST) ? '0 : r_scan_addr + ADDR_W'(1);
        w_dead_next  = DEAD_LD;
        w_wrap_next  = (r_scan_addr == ADDR_LAST);
      end else begin
        // Hold freezes the step timing only; blanking keeps draining.
        w_presc_next = io_bus.i_hold ? r_presc : r_presc + PRE_W'(1);
        w_addr_next  = r_scan_addr;
        w_dead_next  = (r_dead != '0) ? r_dead - DED_W'(1) : '0;
        w_wrap_next  = 1'b0;
      end
      w_sel_next = w_addr_next;
    end
  end

  always_comb begin
    w_eq_next = '1;
    if (w_en && (w_dead_next == '0)) begin
      w_eq_next = ~(OUT_W'(1) << w_sel_next);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc     <= '0;
      r_scan_addr <= '0;
      r_dead      <= '0;
      r_eq        <= '1;
      r_wrap      <= 1'b0;
    end else begin
      r_presc     <= w_presc_next;
      r_scan_addr <= w_addr_next;
      r_dead      <= w_dead_next;
      r_eq        <= w_eq_next;
      r_wrap      <= w_wrap_next;
    end
  end

  assign io_bus.o_eq        = r_eq;
  assign io_bus.o_scan_addr = r_scan_addr;
  assign io_bus.o_wrap      = r_wrap;
endmodule

// File: tb/tb_decoder_scan_nx.sv
// Bench for decoder_scan_nx: two instances (full range and SCAN_LAST=5) against an
// arithmetic model that derives the scan position from counts of un-held scan cycles.
module tb_decoder_scan_nx;
  logic       clk;
  logic       rst;
  logic [2:0] data_in;
  logic [3:1] enable;
  logic       mode;
  logic       hold;

  int compared;
  int mismatched;

  decoder_scan_nx_if #(.ADDR_W(3)) if_a ();
  decoder_scan_nx_if #(.ADDR_W(3)) if_b ();

  assign if_a.i_data_in = data_in;
  assign if_a.i_enable  = enable;
  assign if_a.i_mode    = mode;
  assign if_a.i_hold    = hold;
  assign if_b.i_data_in = data_in;
  assign if_b.i_enable  = enable;
  assign if_b.i_mode    = mode;
  assign if_b.i_hold    = hold;

  decoder_scan_nx #(.ADDR_W(3), .SCAN_DIV(4), .SCAN_LAST(7), .DEAD(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .io_bus(if_a)
  );
  decoder_scan_nx #(.ADDR_W(3), .SCAN_DIV(4), .SCAN_LAST(5), .DEAD(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .io_bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: n = un-held scan cycles since entry, since = cycles since last step.
  localparam int DIV = 4;
  localparam int DED = 1;
  int         m_n     [2];
  int         m_since [2];
  int         m_addr  [2];
  logic [7:0] m_eq    [2];
  logic       m_wrap  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_since[i] = 1000; m_addr[i] = 0; m_eq[i] = 8'hFF; m_wrap[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int  last;
      int  sel;
      bit  step;
      bit  en;
      last = (i == 0) ? 7 : 5;
      step = 1'b0;
      if (!mode) begin
        m_n[i] = 0; m_since[i] = 1000; m_addr[i] = 0; m_wrap[i] = 1'b0;
        sel = int'(data_in);
      end else begin
        if (!hold) begin
          m_n[i] = m_n[i] + 1;
          step = (m_n[i] % DIV) == 0;
        end
        m_since[i] = step ? 0 : ((m_since[i] < 1000) ? m_since[i] + 1 : 1000);
        m_addr[i]  = (m_n[i] / DIV) % (last + 1);
        m_wrap[i]  = step && (m_addr[i] == 0);
        sel = m_addr[i];
      end
      en = (enable == 3'b001);
      m_eq[i] = (!en || (m_since[i] < DED)) ? 8'hFF : ~(8'd1 << sel);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("eq_a",   {24'd0, if_a.o_eq},        {24'd0, m_eq[0]});
    chk("addr_a", {29'd0, if_a.o_scan_addr}, m_addr[0]);
    chk("wrap_a", {31'd0, if_a.o_wrap},      {31'd0, m_wrap[0]});
    chk("eq_b",   {24'd0, if_b.o_eq},        {24'd0, m_eq[1]});
    chk("addr_b", {29'd0, if_b.o_scan_addr}, m_addr[1]);
    chk("wrap_b", {31'd0, if_b.o_wrap},      {31'd0, m_wrap[1]});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Called just after an edge; the reset pulse lies strictly between edges.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_eq_a",   {24'd0, if_a.o_eq}, 32'hFF);
    chk("rst_addr_a", {29'd0, if_a.o_scan_addr}, 32'd0);
    chk("rst_wrap_a", {31'd0, if_a.o_wrap}, 32'd0);
    rst = 1'b0;
  endtask

  logic [7:0] exp_seq [8];
  int         wraps_a;
  int         wraps_b;
  bit         bad_b;
  logic [2:0] addr_before;

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; mode = 1'b0; hold = 1'b0; enable = 3'b001; data_in = 3'd0;
    model_reset();
    #2;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Direct decode
    data_in = 3'd0; cyc(); chk("dir_0", {24'd0, if_a.o_eq}, 32'hFE);
    data_in = 3'd5; cyc(); chk("dir_5", {24'd0, if_a.o_eq}, 32'hDF);
    data_in = 3'd7; cyc(); chk("dir_7", {24'd0, if_a.o_eq}, 32'h7F);
    enable = 3'b011; cyc(); chk("dir_dis2", {24'd0, if_a.o_eq}, 32'hFF);
    enable = 3'b000; cyc(); chk("dir_dis1", {24'd0, if_a.o_eq}, 32'hFF);

    // Enter scan with DataIn=0 so the entry pattern starts on FE
    enable = 3'b001; data_in = 3'd0; cyc();
    exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFE; exp_seq[2] = 8'hFE; exp_seq[3] = 8'hFF;
    exp_seq[4] = 8'hFD; exp_seq[5] = 8'hFD; exp_seq[6] = 8'hFD; exp_seq[7] = 8'hFF;
    mode = 1'b1;
    wraps_a = 0; wraps_b = 0; bad_b = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      cyc();
      if (k <= 8) chk("scan_seq", {24'd0, if_a.o_eq}, {24'd0, exp_seq[k-1]});
      if (k == 32) chk("wrap_step_a", {28'd0, if_a.o_wrap, if_a.o_scan_addr}, {28'd0, 1'b1, 3'd0});
      if (if_a.o_wrap) wraps_a++;
      if (if_b.o_wrap) wraps_b++;
      if (if_b.o_eq == 8'hBF || if_b.o_eq == 8'h7F || if_b.o_scan_addr > 3'd5) bad_b = 1'b1;
    end
    chk("wraps_a", wraps_a, 1);
    chk("wraps_b", wraps_b, 2);
    chk("range_b", {31'd0, bad_b}, 32'd0);

    // Asynchronous reset in the middle of a scan
    do_reset();

    // Hold at prescaler=2, ScanAddr=3 (14 scan cycles after entry)
    for (int k = 1; k <= 14; k++) cyc();
    chk("pre_hold_addr", {29'd0, if_a.o_scan_addr}, 32'd3);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("hold_addr", {29'd0, if_a.o_scan_addr}, 32'd3);
      chk("hold_eq",   {24'd0, if_a.o_eq}, 32'hF7);
    end
    hold = 1'b0;
    cyc(); chk("rel1_addr", {29'd0, if_a.o_scan_addr}, 32'd3);
    cyc(); chk("rel2_addr", {29'd0, if_a.o_scan_addr}, 32'd4);

    // Disabled during scan
    addr_before = if_a.o_scan_addr;
    enable = 3'b101;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("dis_eq", {24'd0, if_a.o_eq}, 32'hFF);
    end
    chk("dis_adv", {29'd0, if_a.o_scan_addr}, {29'd0, 3'(addr_before + 3'd2)});
    enable = 3'b001;
    cyc();

    // Randomised traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) < 3) mode = ~mode;
      hold    = ($urandom_range(0, 3) == 0);
      enable  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
      data_in = 3'($urandom_range(0, 7));
      cyc();
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
